// File: rtl/reg_bank_hs.sv
// Parametrised register bank with valid/ready request/response handshake and byte-strobed writes.
// Optional hardware sweep-clear engine is built when REG_BANK_HS_SWEEP_CLR_EN is defined.
module reg_bank_hs #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    input  logic                  clr_start,
    output logic                  clr_busy
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic [ADDR_W:0]   w_addr_ext;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_wmask;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_req_fire;
    logic              w_wr_en;
    logic              w_sweep_clr;
    logic [IDX_W-1:0]  w_sweep_idx;

    // Extra top bit lets DEPTH == 2^ADDR_W compare correctly.
    assign w_addr_ext = {1'b0, req_addr};
    assign w_in_range = (w_addr_ext < (ADDR_W+1)'(DEPTH));
    assign w_idx      = req_addr[IDX_W-1:0];
    assign w_rd_data  = r_mem[w_idx];

    for (genvar gi = 0; gi < NB; gi++) begin : g_mask
        assign w_wmask[gi*8 +: 8] = {8{req_wstrb[gi]}};
    end

    assign req_ready  = !clr_busy && (!r_rsp_valid || rsp_ready);
    assign w_req_fire = req_valid && req_ready;
    assign w_wr_en    = w_req_fire && req_write && w_in_range;

`ifdef REG_BANK_HS_SWEEP_CLR_EN
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (clr_start) begin
                    w_state_next = ST_SWEEP;
                    w_idx_next   = '0;
                end
            end
            ST_SWEEP: begin
                w_idx_next = r_idx + 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_sweep_clr = (r_state == ST_SWEEP);
    assign w_sweep_idx = r_idx;
    assign clr_busy    = w_sweep_clr;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_start;
    assign w_sweep_clr  = 1'b0;
    assign w_sweep_idx  = '0;
    assign clr_busy     = 1'b0;
`endif

    // Sweep and request writes never coincide: requests are blocked while sweeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_sweep_clr) begin
                r_mem[w_sweep_idx] <= '0;
            end
            if (w_wr_en) begin
                r_mem[w_idx] <= (w_rd_data & ~w_wmask) | (req_wdata & w_wmask);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_req_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (!req_write && w_in_range) ? w_rd_data : '0;
            r_rsp_err   <= !w_in_range;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: doc/reg_bank_hs.md
# reg_bank_hs

Parametrised register bank with a valid/ready request/response interface, byte-strobed writes and address range checking. Sits between the SPI command decoder and the control/status fabric as the next-generation register store. Width and depth are parameters, so the same block serves narrow configuration banks and wide data banks. An optional sweep engine clears the whole bank in hardware.

## Interface
- DATA_W, 16, data width in bits; must be a multiple of 8, minimum 8
- ADDR_W, 8, address width
- DEPTH, 256, number of implemented entries; 1 <= DEPTH <= 2^ADDR_W
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  bank can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  entry address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  byte enables; bit k covers bits [8k+7:8k]
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  address out of range (req_addr >= DEPTH)
- clr_start  in  1  start bank sweep (see Configuration)
- clr_busy  out  1  sweep in progress

## Operation
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. A response is accepted on a rising edge where rsp_valid && rsp_ready.
- req_ready = !clr_busy && (!rsp_valid || rsp_ready). This gives one outstanding response, and a new request can be accepted in the same cycle the previous response drains.
- Write, in range: each byte with req_wstrb=1 is written at the accept edge. Other bytes keep their value. An all-zero strobe writes nothing. Response: rsp_err=0, rsp_rdata=0.
- Read, in range: rsp_rdata = entry contents at the accept edge, including any write accepted on an earlier edge.
- Out of range, read or write: storage is unchanged. Response: rsp_err=1, rsp_rdata=0.
- Response registers (rsp_valid, rsp_rdata, rsp_err) hold their values while rsp_valid && !rsp_ready.
- Reset (async, any time, including mid-handshake or mid-sweep):
  - all entries = 0
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
  - clr_busy = 0, FSM state = IDLE
  - req_ready = 1 after reset
- Sweep FSM (active only with the macro):
  - IDLE -> SWEEP when clr_start=1 in IDLE. The sweep index is loaded with 0.
  - SWEEP: clears entry[index] each cycle and increments index. SWEEP -> IDLE on the edge that clears entry DEPTH-1.
  - clr_start during SWEEP is ignored.

## Timing
- Request-to-response latency: 1 cycle. rsp_valid rises on the edge that accepts the request.
- Sustained throughput with rsp_ready=1: one request per cycle.
- clr_start and a request handshake in the same IDLE cycle: the request is accepted and completes first. clr_busy=1 from the next edge.
- clr_busy is high for exactly DEPTH cycles. req_ready=0 for all of them.
- A response already pending when a sweep starts still drains during SWEEP.
- A read of entry N accepted right after clr_busy falls returns 0.

## Configuration
- REG_BANK_HS_SWEEP_CLR_EN defined: the sweep FSM and index counter are built and behave as described above.
- Not defined: no sweep logic. clr_start is ignored, clr_busy is tied to 0, and req_ready = !rsp_valid || rsp_ready. Port list is identical in both builds.

## Test plan
- Reset: with default parameters, assert rst_n=0 mid-transfer -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; read of address 0x05 returns 0x0000.
- Strobed write: write addr 0x10 data 0xABCD strb 2'b11, then data 0x1234 strb 2'b01 -> read addr 0x10 returns 0xAB34, rsp_err=0.
- Range check: instance DEPTH=200, write addr 200 data 0xFFFF -> rsp_err=1, rsp_rdata=0; read addr 199 still returns its prior value.
- Back-pressure: hold rsp_ready=0 after a read of 0x10 -> req_ready=0, response stays 0xAB34. Raise rsp_ready with a new request valid -> both handshakes complete on the same edge.
- Streaming: 8 back-to-back writes then 8 reads with rsp_ready=1 -> one response per cycle, data matches, no bubbles.
- Sweep (macro defined): fill entries 0..255 with nonzero data, pulse clr_start -> clr_busy high for 256 cycles and req_ready=0 throughout; afterwards all reads return 0. Macro undefined: same stimulus -> clr_busy stays 0 and data is unchanged.
